// File: rtl/img_pkg.sv
// Shared types and defaults for the TFT image-window read path.
package img_pkg;

    localparam int IMG_W      = 200;
    localparam int IMG_H      = 200;
    localparam int IMG_PIXELS = IMG_W * IMG_H;

    typedef logic [15:0] rgb565_t;

    localparam rgb565_t BG_COLOR = 16'h0000;

    typedef enum logic {WAIT = 1'b0, SHOW = 1'b1} state_t;

    // True when coordinate c lies in [lo, hi) and inside the active area (c < lim).
    function automatic logic in_span(input logic [11:0] c, input logic [12:0] lo,
                                     input logic [12:0] hi, input logic [12:0] lim);
        return ({1'b0, c} >= lo) && ({1'b0, c} < hi) && ({1'b0, c} < lim);
    endfunction

endpackage

// File: rtl/img_pipe_dly.sv
// Fixed-depth shift register that carries request flags alongside the RAM read latency.
module img_pipe_dly #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_sr;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++)
                r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/img_ram_rd_tft.sv
// Maps TFT pixel requests onto frame-RAM reads for an image window; background elsewhere.
module img_ram_rd_tft
    import img_pkg::*;
#(
    parameter int      H_DISP   = 800,
    parameter int      V_DISP   = 480,
    parameter int      IMG_W    = img_pkg::IMG_W,
    parameter int      IMG_H    = img_pkg::IMG_H,
    parameter int      IMG_X0   = 300,
    parameter int      IMG_Y0   = 140,
    parameter int      RD_LAT   = 1,
    parameter rgb565_t BG_COLOR = img_pkg::BG_COLOR
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        ram_wr_en,
    input  logic [15:0] ram_wr_addr,
    input  logic        frame_clr,
    input  logic        data_req,
    input  logic [11:0] hcount,
    input  logic [11:0] vcount,
    output logic        ram_rd_en,
    output logic [15:0] ram_rd_addr,
    input  logic [15:0] ram_rd_data,
    output logic [15:0] disp_data,
    output logic        disp_valid,
    output logic        frame_ready
);

    localparam logic [15:0] LAST_ADDR = 16'(IMG_W * IMG_H - 1);
    localparam logic [12:0] X_LO  = 13'(IMG_X0);
    localparam logic [12:0] X_HI  = 13'(IMG_X0 + IMG_W);
    localparam logic [12:0] Y_LO  = 13'(IMG_Y0);
    localparam logic [12:0] Y_HI  = 13'(IMG_Y0 + IMG_H);
    localparam logic [12:0] H_LIM = 13'(H_DISP);
    localparam logic [12:0] V_LIM = 13'(V_DISP);

    state_t      r_state;
    logic        r_loaded;
    logic [15:0] r_cnt;
    logic        r_req0;

    state_t      w_nxt;
    logic        w_origin;
    logic        w_in_win;
    logic        w_show;
    logic [15:0] w_addr;
    logic [1:0]  w_dly;

    assign w_origin = data_req && (hcount == 12'd0) && (vcount == 12'd0);
    assign w_in_win = in_span(hcount, X_LO, X_HI, H_LIM) && in_span(vcount, Y_LO, Y_HI, V_LIM);

    // A loaded frame only goes live at the frame origin so a scan never mixes two images.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            WAIT:    if (r_loaded && w_origin && !frame_clr) w_nxt = SHOW;
            SHOW:    if (frame_clr) w_nxt = WAIT;
            default: w_nxt = WAIT;
        endcase
    end

    assign w_show = data_req && w_in_win && (w_nxt == SHOW);
    assign w_addr = w_origin ? 16'd0 : r_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= WAIT;
            frame_ready <= 1'b0;
            r_loaded    <= 1'b0;
            r_cnt       <= '0;
            r_req0      <= 1'b0;
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= '0;
        end else begin
            r_state     <= w_nxt;
            frame_ready <= (w_nxt == SHOW);
            if (frame_clr)
                r_loaded <= 1'b0;
            else if (ram_wr_en && (ram_wr_addr == LAST_ADDR))
                r_loaded <= 1'b1;
            r_req0    <= data_req;
            ram_rd_en <= w_show;
            if (w_show) begin
                ram_rd_addr <= w_addr;
                r_cnt       <= (w_addr == LAST_ADDR) ? w_addr : w_addr + 16'd1;
            end else if (w_origin) begin
                r_cnt <= '0;
            end
        end
    end

    img_pipe_dly #(
        .DEPTH (RD_LAT),
        .WIDTH (2)
    ) u_dly (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_d     ({r_req0, ram_rd_en}),
        .o_q     (w_dly)
    );

    // Reads already in flight when the frame is cleared still return, but are masked here.
    assign disp_valid = w_dly[1];
    assign disp_data  = (w_dly[0] && (r_state == SHOW)) ? ram_rd_data : BG_COLOR;

endmodule

// File: tb/tb_img_ram_rd_tft.sv
// Scoreboard bench: two instances (RD_LAT 1 and 2) on a reduced display geometry.
module tb_img_ram_rd_tft;

    localparam int HD = 40, VD = 24, IW = 10, IH = 8, X0 = 15, Y0 = 7;
    localparam int PIX = IW * IH;
    localparam int LAST = PIX - 1;
    localparam logic [15:0] BG1 = 16'h0000;
    localparam logic [15:0] BG2 = 16'h07E0;

    typedef struct { int cyc; logic [15:0] data; } exp_t;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        ram_wr_en = 1'b0;
    logic [15:0] ram_wr_addr = '0;
    logic        frame_clr = 1'b0;
    logic        data_req = 1'b0;
    logic [11:0] hcount = '0;
    logic [11:0] vcount = '0;

    logic        rd_en1, rd_en2, vld1, vld2, rdy1, rdy2;
    logic [15:0] rd_addr1, rd_addr2, dd1, dd2;
    logic [15:0] m1_s1, m2_s1, m2_s2;

    int   cyc = 0;
    int   vectors = 0;
    int   errs = 0;
    int   n_rd = 0;
    int   n_vld = 0;
    bit   m_loaded = 0;
    bit   m_show = 0;
    exp_t q1[$], q2[$], aq[$];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    img_ram_rd_tft #(.H_DISP(HD), .V_DISP(VD), .IMG_W(IW), .IMG_H(IH), .IMG_X0(X0),
                     .IMG_Y0(Y0), .RD_LAT(1), .BG_COLOR(BG1)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .frame_clr(frame_clr), .data_req(data_req), .hcount(hcount), .vcount(vcount),
        .ram_rd_en(rd_en1), .ram_rd_addr(rd_addr1), .ram_rd_data(m1_s1),
        .disp_data(dd1), .disp_valid(vld1), .frame_ready(rdy1));

    img_ram_rd_tft #(.H_DISP(HD), .V_DISP(VD), .IMG_W(IW), .IMG_H(IH), .IMG_X0(X0),
                     .IMG_Y0(Y0), .RD_LAT(2), .BG_COLOR(BG2)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .frame_clr(frame_clr), .data_req(data_req), .hcount(hcount), .vcount(vcount),
        .ram_rd_en(rd_en2), .ram_rd_addr(rd_addr2), .ram_rd_data(m2_s2),
        .disp_data(dd2), .disp_valid(vld2), .frame_ready(rdy2));

    // RAM models: stored word equals its address.
    always @(posedge Clk) begin
        if (rd_en1) m1_s1 <= rd_addr1;
        if (rd_en2) m2_s1 <= rd_addr2;
        m2_s2 <= m2_s1;
    end

    always @(negedge Clk) begin
        exp_t e;
        if (vld1 === 1'b1) n_vld++;
        if (q1.size() > 0 && q1[0].cyc == cyc) begin
            e = q1.pop_front();
            vectors++;
            if (vld1 !== 1'b1 || dd1 !== e.data) begin
                errs++;
                $display("FAIL pix_lat1 cyc %0d: got valid=%b data=%h, want valid=1 data=%h", cyc, vld1, dd1, e.data);
            end
        end else if (vld1 !== 1'b0) begin
            vectors++; errs++;
            $display("FAIL stray_valid_lat1 cyc %0d: got valid=%b, want 0", cyc, vld1);
        end
        if (q2.size() > 0 && q2[0].cyc == cyc) begin
            e = q2.pop_front();
            vectors++;
            if (vld2 !== 1'b1 || dd2 !== e.data) begin
                errs++;
                $display("FAIL pix_lat2 cyc %0d: got valid=%b data=%h, want valid=1 data=%h", cyc, vld2, dd2, e.data);
            end
        end else if (vld2 !== 1'b0) begin
            vectors++; errs++;
            $display("FAIL stray_valid_lat2 cyc %0d: got valid=%b, want 0", cyc, vld2);
        end
        if (rd_en1 === 1'b1) n_rd++;
        if (aq.size() > 0 && aq[0].cyc == cyc) begin
            e = aq.pop_front();
            vectors++;
            if (rd_en1 !== 1'b1 || rd_addr1 !== e.data || rd_en2 !== 1'b1 || rd_addr2 !== e.data) begin
                errs++;
                $display("FAIL rd_addr cyc %0d: got en=%b addr=%0d, want en=1 addr=%0d", cyc, rd_en1, rd_addr1, e.data);
            end
        end else if (rd_en1 !== 1'b0 || rd_en2 !== 1'b0) begin
            vectors++; errs++;
            $display("FAIL stray_rd cyc %0d: got en=%b/%b addr=%0d, want no read", cyc, rd_en1, rd_en2, rd_addr1);
        end
    end

    task automatic drive(input bit req, input int h, input int v, input bit wr, input int wa, input bit clr);
        bit nxt, win, shown;
        logic [15:0] a;
        @(posedge Clk); #1;
        vectors++;
        if (rdy1 !== m_show || rdy2 !== m_show) begin
            errs++;
            $display("FAIL frame_ready cyc %0d: got %b/%b, want %b", cyc, rdy1, rdy2, m_show);
        end
        data_req = req; hcount = 12'(h); vcount = 12'(v);
        ram_wr_en = wr; ram_wr_addr = 16'(wa); frame_clr = clr;
        nxt = m_show ? !clr : (m_loaded && !clr && req && h == 0 && v == 0);
        if (m_show && clr) begin
            foreach (q1[i]) if (q1[i].cyc > cyc) q1[i].data = BG1;
            foreach (q2[i]) if (q2[i].cyc > cyc) q2[i].data = BG2;
        end
        win   = (h >= X0) && (h < X0 + IW) && (h < HD) && (v >= Y0) && (v < Y0 + IH) && (v < VD);
        shown = req && win && nxt;
        a     = 16'((v - Y0) * IW + (h - X0));
        if (req) begin
            q1.push_back('{cyc + 2, shown ? a : BG1});
            q2.push_back('{cyc + 3, shown ? a : BG2});
        end
        if (shown) aq.push_back('{cyc + 1, a});
        m_loaded = clr ? 1'b0 : ((wr && wa == LAST) ? 1'b1 : m_loaded);
        m_show   = nxt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic scan(input int gap, input int ex, input int ey, input bit eclr, input bit ewr);
        for (int v = 0; v < VD; v++) begin
            for (int h = 0; h < HD; h++) begin
                bit hit;
                hit = (h == ex) && (v == ey);
                drive(1, h, v, ewr && hit, LAST, eclr && hit);
            end
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic check_quiet(input string name);
        vectors++;
        if (rd_en1 !== 1'b0 || rd_addr1 !== 16'd0 || vld1 !== 1'b0 || dd1 !== 16'd0 || rdy1 !== 1'b0 ||
            rd_en2 !== 1'b0 || rd_addr2 !== 16'd0 || vld2 !== 1'b0 || dd2 !== BG2 || rdy2 !== 1'b0) begin
            errs++;
            $display("FAIL %s: got en=%b addr=%0d vld=%b data=%h rdy=%b, want all zero", name, rd_en1, rd_addr1, vld1, dd1, rdy1);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1 check_quiet("reset_state");
        @(negedge Clk) Reset_n = 1'b1;
    endtask

    task automatic test_no_load();
        n_vld = 0; n_rd = 0;
        scan(2, -1, -1, 0, 0);
        idle(4);
        vectors++;
        if (n_vld != HD * VD || n_rd != 0) begin
            errs++;
            $display("FAIL no_load_counts: got valid=%0d reads=%0d, want %0d and 0", n_vld, n_rd, HD * VD);
        end
    endtask

    task automatic test_load();
        for (int a = 0; a < PIX; a++) drive(0, 0, 0, 1, a, 0);
        idle(2);
        n_rd = 0;
        scan(2, -1, -1, 0, 0);
        idle(4);
        vectors++;
        if (n_rd != PIX) begin
            errs++;
            $display("FAIL reads_per_frame: got %0d, want %0d", n_rd, PIX);
        end
    endtask

    task automatic test_back_to_back();
        n_rd = 0;
        scan(0, -1, -1, 0, 0);
        idle(4);
        vectors++;
        if (n_rd != PIX) begin
            errs++;
            $display("FAIL b2b_reads: got %0d, want %0d", n_rd, PIX);
        end
    endtask

    task automatic test_late_load();
        drive(0, 0, 0, 0, 0, 1);
        scan(1, 20, 12, 0, 1);
        scan(1, -1, -1, 0, 0);
        idle(4);
    endtask

    task automatic test_clr();
        scan(1, X0 + 5, Y0 + 3, 1, 0);
        scan(1, -1, -1, 0, 0);
        drive(0, 0, 0, 1, LAST, 1);
        scan(1, -1, -1, 0, 0);
        drive(0, 0, 0, 1, LAST, 0);
        scan(0, -1, -1, 0, 0);
        idle(4);
    endtask

    task automatic test_async_reset();
        for (int v = 0; v <= Y0 + 2; v++)
            for (int h = 0; h < HD; h++)
                if (v < Y0 + 2 || h <= X0 + 3) drive(1, h, v, 0, 0, 0);
        #2 Reset_n = 1'b0;
        data_req = 1'b0; ram_wr_en = 1'b0; frame_clr = 1'b0;
        q1.delete(); q2.delete(); aq.delete();
        m_show = 0; m_loaded = 0;
        #1 check_quiet("async_reset");
        repeat (2) @(posedge Clk);
        @(negedge Clk) Reset_n = 1'b1;
        #1 check_quiet("after_reset");
        scan(1, -1, -1, 0, 0);
        drive(0, 0, 0, 1, LAST, 0);
        n_rd = 0;
        scan(1, -1, -1, 0, 0);
        idle(4);
        vectors++;
        if (n_rd != PIX) begin
            errs++;
            $display("FAIL reads_after_reset: got %0d, want %0d", n_rd, PIX);
        end
    endtask

    initial begin
        test_reset();
        test_no_load();
        test_load();
        test_back_to_back();
        test_late_load();
        test_clr();
        test_async_reset();
        idle(5);
        vectors++;
        if (q1.size() != 0 || q2.size() != 0 || aq.size() != 0) begin
            errs++;
            $display("FAIL drain: got pending %0d/%0d/%0d, want 0", q1.size(), q2.size(), aq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
